// File: rtl/riscv_lsu.sv
// Load/store unit: maps core byte-addressed requests onto a word-aligned
// data-memory bus with byte enables, runs the grant/response handshake and
// returns lane-extracted, sign/zero-extended load data.
module riscv_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic        core_require,
  input  logic        core_write_enable,
  input  logic [2:0]  core_size,
  output logic [31:0] core_read_data,
  output logic        core_stall_signal,
  input  logic [31:0] memory_read_data,
  input  logic        memory_begin_signal,
  input  logic        memory_end_signal,
  output logic        memory_require,
  output logic        memory_write_enable,
  output logic [3:0]  memory_byte_enable_map,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write_data
);

  localparam int unsigned DataW = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       offset;
  logic             is_byte;
  logic             is_half;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [DataW-1:0] load_data;

  assign offset  = core_address[1:0];
  assign is_byte = (core_size == 3'd0) || (core_size == 3'd4);
  assign is_half = (core_size == 3'd1) || (core_size == 3'd5);

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake next-state and strobes; stall drops on the completing cycle.
  always_comb begin
    state_d             = state_q;
    memory_require      = 1'b0;
    memory_write_enable = 1'b0;
    core_stall_signal   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_require) begin
          memory_require      = 1'b1;
          memory_write_enable = core_write_enable;
          core_stall_signal   = 1'b1;
          if (memory_begin_signal) state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        core_stall_signal = core_require & ~memory_end_signal;
        if (memory_end_signal) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      memory_require      = 1'b0;
      memory_write_enable = 1'b0;
      core_stall_signal   = 1'b0;
    end
  end

  // Word-aligned address and lane enables; half uses offset[1] only.
  always_comb begin
    memory_address = {core_address[31:2], 2'b00};
    if (is_byte)      memory_byte_enable_map = 4'(4'b0001 << offset);
    else if (is_half) memory_byte_enable_map = 4'(4'b0011 << {offset[1], 1'b0});
    else              memory_byte_enable_map = 4'b1111;
  end

  // Store data replicated across all lanes so any enabled lane is correct.
  always_comb begin
    if (is_byte)      memory_write_data = {4{core_write_data[7:0]}};
    else if (is_half) memory_write_data = {2{core_write_data[15:0]}};
    else              memory_write_data = core_write_data;
  end

  // Lane extraction and extension of the returned word.
  always_comb begin
    unique case (offset)
      2'd0:    byte_sel = memory_read_data[7:0];
      2'd1:    byte_sel = memory_read_data[15:8];
      2'd2:    byte_sel = memory_read_data[23:16];
      default: byte_sel = memory_read_data[31:24];
    endcase
    half_sel = offset[1] ? memory_read_data[31:16] : memory_read_data[15:0];
    unique case (core_size)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_data = {24'd0, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = memory_read_data;
    endcase
    core_read_data = reset ? load_data : '0;
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: decode vector table, hand-written
// handshake sequences and randomized transactions against a reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_address;
  logic [31:0] core_write_data;
  logic        core_require;
  logic        core_write_enable;
  logic [2:0]  core_size;
  logic [31:0] core_read_data;
  logic        core_stall_signal;
  logic [31:0] memory_read_data;
  logic        memory_begin_signal;
  logic        memory_end_signal;
  logic        memory_require;
  logic        memory_write_enable;
  logic [3:0]  memory_byte_enable_map;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;

  riscv_lsu dut (
    .clk                    (clk),
    .reset                  (reset),
    .core_address           (core_address),
    .core_write_data        (core_write_data),
    .core_require           (core_require),
    .core_write_enable      (core_write_enable),
    .core_size              (core_size),
    .core_read_data         (core_read_data),
    .core_stall_signal      (core_stall_signal),
    .memory_read_data       (memory_read_data),
    .memory_begin_signal    (memory_begin_signal),
    .memory_end_signal      (memory_end_signal),
    .memory_require         (memory_require),
    .memory_write_enable    (memory_write_enable),
    .memory_byte_enable_map (memory_byte_enable_map),
    .memory_address         (memory_address),
    .memory_write_data      (memory_write_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: is a granted transaction outstanding?
  bit pending = 1'b0;

  // Sampled outputs from the most recent cycle.
  logic s_req, s_we, s_stall;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  map;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic int m_nbytes(input logic [2:0] sz);
    if (sz == 3'd0 || sz == 3'd4) return 1;
    if (sz == 3'd1 || sz == 3'd5) return 2;
    return 4;
  endfunction

  // Offset rounded down to the access size (ignores unused low bits).
  function automatic int m_off(input logic [31:0] a, input logic [2:0] sz);
    int o = int'(a[1:0]);
    int n = m_nbytes(sz);
    return o - (o % n);
  endfunction

  function automatic logic [3:0] m_map(input logic [31:0] a, input logic [2:0] sz);
    int m = ((1 << m_nbytes(sz)) - 1) << m_off(a, sz);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] sz);
    int n = m_nbytes(sz);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic [2:0] sz,
                                          input logic [31:0] rd);
    int n = m_nbytes(sz);
    logic [31:0] mask, v;
    if (n == 4) return rd;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rd >> (8 * m_off(a, sz))) & mask;
    if ((sz == 3'd0 || sz == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Compare all outputs against the model at negedge, then advance the model.
  task automatic cyc(input string tag);
    logic e_req, e_stall;
    @(negedge clk);
    e_req   = reset && !pending && core_require;
    e_stall = reset && core_require && !(pending && memory_end_signal);
    s_req   = memory_require;
    s_we    = memory_write_enable;
    s_stall = core_stall_signal;
    chk({tag, ".req"},   32'(memory_require),      32'(e_req));
    chk({tag, ".we"},    32'(memory_write_enable), 32'(e_req && core_write_enable));
    chk({tag, ".stall"}, 32'(core_stall_signal),   32'(e_stall));
    chk({tag, ".addr"},  memory_address,           core_address & 32'hFFFF_FFFC);
    chk({tag, ".map"},   32'(memory_byte_enable_map), 32'(m_map(core_address, core_size)));
    chk({tag, ".wdata"}, memory_write_data,        m_wdata(core_write_data, core_size));
    chk({tag, ".rdata"}, core_read_data,
        reset ? m_rdata(core_address, core_size, memory_read_data) : 32'd0);
    @(posedge clk);
    if (!reset)                                            pending = 1'b0;
    else if (!pending && core_require && memory_begin_signal) pending = 1'b1;
    else if (pending && memory_end_signal)                 pending = 1'b0;
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [2:0] sz, input logic we,
                         input logic [31:0] wd);
    core_require      = 1'b1;
    core_address      = a;
    core_size         = sz;
    core_write_enable = we;
    core_write_data   = wd;
  endtask

  initial begin
    int nreq, nstall, ncyc;

    vt[0]  = '{32'h104, 3'd2, 32'hA5A5A5A5, 32'hDEADBEEF, 4'b1111, 32'hA5A5A5A5, 32'hDEADBEEF};
    vt[1]  = '{32'h103, 3'd0, 32'h12345678, 32'h80FF7F01, 4'b1000, 32'h78787878, 32'hFFFFFF80};
    vt[2]  = '{32'h103, 3'd4, 32'h12345678, 32'h80FF7F01, 4'b1000, 32'h78787878, 32'h00000080};
    vt[3]  = '{32'h102, 3'd1, 32'h12345678, 32'h80FF7F01, 4'b1100, 32'h56785678, 32'hFFFF80FF};
    vt[4]  = '{32'h102, 3'd5, 32'h12345678, 32'h80FF7F01, 4'b1100, 32'h56785678, 32'h000080FF};
    vt[5]  = '{32'h021, 3'd0, 32'h12345678, 32'h80FF7F01, 4'b0010, 32'h78787878, 32'h0000007F};
    vt[6]  = '{32'h022, 3'd1, 32'h12345678, 32'h80FF7F01, 4'b1100, 32'h56785678, 32'hFFFF80FF};
    vt[7]  = '{32'h100, 3'd0, 32'h12345678, 32'h80FF7F01, 4'b0001, 32'h78787878, 32'h00000001};
    vt[8]  = '{32'h102, 3'd0, 32'h12345678, 32'h80FF7F01, 4'b0100, 32'h78787878, 32'hFFFFFFFF};
    vt[9]  = '{32'h103, 3'd1, 32'h12345678, 32'h80FF7F01, 4'b1100, 32'h56785678, 32'hFFFF80FF};
    vt[10] = '{32'h107, 3'd2, 32'h12345678, 32'h80FF7F01, 4'b1111, 32'h12345678, 32'h80FF7F01};
    vt[11] = '{32'h101, 3'd3, 32'h12345678, 32'h80FF7F01, 4'b1111, 32'h12345678, 32'h80FF7F01};
    vt[12] = '{32'h102, 3'd7, 32'h12345678, 32'h80FF7F01, 4'b1111, 32'h12345678, 32'h80FF7F01};
    vt[13] = '{32'h101, 3'd5, 32'h12345678, 32'h80FF7F01, 4'b0011, 32'h56785678, 32'h00007F01};

    reset = 1'b0;
    core_require = 1'b1; core_address = 32'h104; core_size = 3'd2;
    core_write_enable = 1'b0; core_write_data = '0;
    memory_read_data = '0; memory_begin_signal = 1'b0; memory_end_signal = 1'b0;

    // Reset held with a request pending: no request, no stall, zero read data.
    cyc("rst0");
    chk("rst.req", 32'(s_req), 32'd0);
    chk("rst.stall", 32'(s_stall), 32'd0);
    cyc("rst1");
    reset = 1'b1;
    cyc("rel");
    chk("rel.req", 32'(s_req), 32'd1);

    // Decode table, exercised with no request outstanding.
    core_require = 1'b0;
    for (int i = 0; i < 14; i++) begin
      core_address = vt[i].addr; core_size = vt[i].size;
      core_write_data = vt[i].wd; memory_read_data = vt[i].rd;
      #1;
      chk($sformatf("vec%0d.map", i), 32'(memory_byte_enable_map), 32'(vt[i].map));
      chk($sformatf("vec%0d.wdata", i), memory_write_data, vt[i].wdata);
      chk($sformatf("vec%0d.rdata", i), core_read_data, vt[i].rdata);
      chk($sformatf("vec%0d.addr", i), memory_address, vt[i].addr & 32'hFFFF_FFFC);
    end
    chk("idle.stall", 32'(core_stall_signal), 32'd0);
    chk("idle.req", 32'(memory_require), 32'd0);

    // LW with minimum latency: grant cycle 0, end cycle 1.
    @(posedge clk); #1;
    set_req(32'h104, 3'd2, 1'b0, '0);
    memory_begin_signal = 1'b1;
    cyc("lw0");
    chk("lw0.stall", 32'(s_stall), 32'd1);
    memory_begin_signal = 1'b0; memory_end_signal = 1'b1; memory_read_data = 32'hDEADBEEF;
    #1;
    chk("lw1.rdata", core_read_data, 32'hDEADBEEF);
    chk("lw1.addr", memory_address, 32'h104);
    cyc("lw1");
    chk("lw1.stall", 32'(s_stall), 32'd0);
    memory_end_signal = 1'b0;

    // SB: store strobe only while requesting.
    set_req(32'h21, 3'd0, 1'b1, 32'h12345678);
    memory_begin_signal = 1'b1;
    cyc("sb0");
    chk("sb0.we", 32'(s_we), 32'd1);
    memory_begin_signal = 1'b0;
    cyc("sb1");
    chk("sb1.we", 32'(s_we), 32'd0);
    chk("sb1.stall", 32'(s_stall), 32'd1);
    memory_end_signal = 1'b1;
    cyc("sb2");
    memory_end_signal = 1'b0;

    // Delayed grant (3 cycles) and end 2 cycles after grant.
    set_req(32'h102, 3'd1, 1'b0, '0);
    memory_read_data = 32'h80FF7F01;
    nreq = 0; nstall = 0; ncyc = 0;
    for (int c = 0; c < 6; c++) begin
      memory_begin_signal = (c == 3);
      memory_end_signal   = (c == 5);
      cyc("dly");
      nreq += int'(s_req); nstall += int'(s_stall); ncyc++;
    end
    chk("dly.req_cycles", 32'(nreq), 32'd4);
    chk("dly.stall_cycles", 32'(nstall), 32'd5);
    chk("dly.txn_cycles", 32'(ncyc), 32'd6);
    memory_begin_signal = 1'b0; memory_end_signal = 1'b0;
    cyc("dly.next");
    chk("dly.next_req", 32'(s_req), 32'd1);

    // Reset pulse during WAIT_RESP, then a stray end.
    memory_begin_signal = 1'b1;
    cyc("rw0");
    memory_begin_signal = 1'b0;
    core_require = 1'b0;
    reset = 1'b0; pending = 1'b0;
    cyc("rw1");
    reset = 1'b1; memory_end_signal = 1'b1;
    cyc("rw2");
    chk("rw2.stall", 32'(s_stall), 32'd0);
    memory_end_signal = 1'b0;
    core_require = 1'b1;
    cyc("rw3");
    chk("rw3.req", 32'(s_req), 32'd1);
    memory_begin_signal = 1'b1;
    cyc("rw4");
    memory_begin_signal = 1'b0; memory_end_signal = 1'b1;
    cyc("rw5");
    memory_end_signal = 1'b0;

    // Randomized transactions with random grant/end delays and idle gaps.
    for (int t = 0; t < 300; t++) begin
      int gd, ed, gap;
      logic [2:0] szs[8];
      szs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        core_require = 1'b0;
        core_address = $urandom; core_size = szs[$urandom_range(0, 7)];
        memory_begin_signal = 1'($urandom); memory_end_signal = 1'($urandom);
        memory_read_data = $urandom;
        cyc("rnd.gap");
      end
      set_req($urandom, szs[$urandom_range(0, 7)], 1'($urandom), $urandom);
      gd = int'($urandom_range(0, 3));
      ed = int'($urandom_range(0, 2));
      for (int g = 0; g <= gd; g++) begin
        memory_begin_signal = (g == gd);
        memory_end_signal   = 1'($urandom);
        memory_read_data    = $urandom;
        cyc("rnd.req");
      end
      for (int e = 0; e <= ed; e++) begin
        memory_begin_signal = 1'($urandom);
        memory_end_signal   = (e == ed);
        memory_read_data    = $urandom;
        cyc("rnd.wait");
      end
      memory_begin_signal = 1'b0; memory_end_signal = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
